// File: rtl/arb_pkg.sv
// arb_pkg: shared widths and FSM state encoding for the instruction/data memory arbiter
package arb_pkg;
    localparam int ADDR_W = 6;
    localparam int BLOCK_W = 32;
    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: picks the winning side from pending requests and the last-grant pointer
module arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic last_d,
    output logic grant_i,
    output logic grant_d
);
    // data wins unless instruction is also waiting and data had the previous grant
    always_comb begin
        grant_d = d_req && (!i_req || !last_d);
        grant_i = i_req && !grant_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block memory port between instruction and data sides;
// define ARB_ROUND_ROBIN_EN for round-robin ties, otherwise data has fixed priority.
module mem_arbiter
    import arb_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);
    state_t state;
    logic started, write_r, last_d, grant_i, grant_d, serving;
    logic [ADDR_W-1:0] addr_r;
    logic [BLOCK_W-1:0] wdata_r;

    arb_pick u_pick (
        .i_req   (I_READ),
        .d_req   (D_READ || D_WRITE),
        .last_d  (last_d),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK)
        last_d <= RESET ? 1'b0 : (state == IDLE && (grant_i || grant_d)) ? grant_d : last_d;
`else
    assign last_d = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            started    <= 1'b0;
            write_r    <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            I_READDATA <= '0;
            D_READDATA <= '0;
        end else begin
            case (state)
                IDLE: if (grant_i || grant_d) begin
                    state   <= grant_d ? SERVE_D : SERVE_I;
                    addr_r  <= grant_d ? D_ADDRESS : I_ADDRESS;
                    wdata_r <= grant_d ? D_WRITEDATA : '0;
                    write_r <= grant_d && D_WRITE;
                end
                SERVE_I, SERVE_D: begin
                    started <= 1'b1;
                    // first serve cycle only arms started, so memory busy is seen at least once
                    if (started && !MEM_BUSYWAIT) begin
                        started <= 1'b0;
                        state   <= (state == SERVE_I) ? RESP_I : RESP_D;
                        if (!write_r && state == SERVE_I) I_READDATA <= MEM_READDATA;
                        if (!write_r && state == SERVE_D) D_READDATA <= MEM_READDATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        serving       = state == SERVE_I || state == SERVE_D;
        MEM_READ      = serving && !write_r;
        MEM_WRITE     = serving && write_r;
        MEM_ADDRESS   = serving ? addr_r : '0;
        MEM_WRITEDATA = serving ? wdata_r : '0;
        I_BUSYWAIT    = I_READ && state != RESP_I;
        D_BUSYWAIT    = (D_READ || D_WRITE) && state != RESP_D;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized scoreboard bench for mem_arbiter with a 4-cycle-busy memory model
module tb_mem_arbiter;
    logic CLK = 0, RESET = 1;
    logic I_READ = 0, D_READ = 0, D_WRITE = 0;
    logic [5:0] I_ADDRESS = 0, D_ADDRESS = 0, MEM_ADDRESS;
    logic [31:0] D_WRITEDATA = 0, I_READDATA, D_READDATA, MEM_WRITEDATA, MEM_READDATA;
    logic I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;

    mem_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errs = 0;
    int rd_cyc = 0, wr_cyc = 0, r0, w0, bc, bc2;
    logic sb_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fn(input logic [5:0] a);
        return {2'b10, a, a, a, a, a};
    endfunction

    // memory model: busy for the first 4 cycles of an access, data valid once busy drops
    logic [31:0] mem [64];
    logic [2:0] cnt = 0;
    logic [5:0] w_addr = 0, poke_a = 0;
    logic [31:0] w_data = 0, poke_d = 0;
    logic init_mem = 0, poke = 0;
    logic [5:0] grant_log [$];

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && cnt < 4;
    assign MEM_READDATA = (MEM_READ && cnt >= 4) ? mem[MEM_ADDRESS] : 32'h0BAD0BAD;

    always @(posedge CLK) begin
        if (init_mem) for (int a = 0; a < 64; a++) mem[a] <= fn(6'(a));
        else if (poke) mem[poke_a] <= poke_d;
        if (MEM_READ || MEM_WRITE) begin
            if (cnt < 4) cnt <= cnt + 1;
            else if (MEM_WRITE) begin
                mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                w_addr <= MEM_ADDRESS;
                w_data <= MEM_WRITEDATA;
            end
        end else cnt <= 0;
    end

    always @(negedge CLK) begin
        if (MEM_READ) rd_cyc++;
        if (MEM_WRITE) wr_cyc++;
        if ((MEM_READ || MEM_WRITE) && cnt == 0) grant_log.push_back(MEM_ADDRESS);
    end

    // reference model and scoreboard
    typedef struct packed {logic wr; logic [5:0] a; logic [31:0] wd; logic [31:0] rd;} dexp_t;
    logic [31:0] ref_mem [64];
    logic [31:0] i_q [$];
    dexp_t d_q [$];
    logic [31:0] d_last;

    always @(negedge CLK) begin
        if (sb_on && !RESET) begin
            if (I_READ && !I_BUSYWAIT) begin
                if (i_q.size() == 0) chk("i_sb_unexpected", 1, 0);
                else chk("i_sb_rdata", I_READDATA, i_q.pop_front());
            end
            if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
                if (d_q.size() == 0) chk("d_sb_unexpected", 1, 0);
                else begin
                    automatic dexp_t e = d_q.pop_front();
                    chk(e.wr ? "d_sb_rdata_hold" : "d_sb_rdata", D_READDATA, e.rd);
                    if (e.wr) begin
                        chk("d_sb_waddr", w_addr, e.a);
                        chk("d_sb_wdata", w_data, e.wd);
                    end
                end
            end
        end
    end

    task automatic do_req(input bit d, input bit rd, input bit wr, input logic [5:0] a,
                          input logic [31:0] wd, output int busy);
        @(posedge CLK); #1;
        if (d) begin D_READ = rd; D_WRITE = wr; D_ADDRESS = a; D_WRITEDATA = wd; end
        else begin I_READ = 1; I_ADDRESS = a; end
        busy = 0;
        while (busy < 200) begin
            @(negedge CLK);
            if (d ? !D_BUSYWAIT : !I_BUSYWAIT) break;
            busy++;
        end
        if (busy >= 200) chk("req_timeout", 1, 0);
        @(posedge CLK); #1;
        if (d) begin D_READ = 0; D_WRITE = 0; end
        else I_READ = 0;
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1 RESET = 1; init_mem = 1;
        @(posedge CLK); #1 RESET = 0; init_mem = 0;
        grant_log.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] exp_ord [4];
        init_mem = 1;
        repeat (2) @(posedge CLK);
        #1 init_mem = 0;
        @(negedge CLK);
        chk("rst_mem_read", MEM_READ, 0);
        chk("rst_mem_write", MEM_WRITE, 0);
        chk("rst_mem_addr", MEM_ADDRESS, 0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 0);
        chk("rst_i_rdata", I_READDATA, 0);
        chk("rst_d_rdata", D_READDATA, 0);
        chk("rst_i_busy_idle", I_BUSYWAIT, 0);
        I_READ = 1; D_WRITE = 1;
        #1 chk("rst_i_busy_req", I_BUSYWAIT, 1);
        chk("rst_d_busy_req", D_BUSYWAIT, 1);
        I_READ = 0; D_WRITE = 0;
        @(posedge CLK); #1 RESET = 0;

        // single instruction read with full latency accounting
        poke = 1; poke_a = 6'h05; poke_d = 32'hDEADBEEF;
        @(posedge CLK); #1 poke = 0;
        r0 = rd_cyc;
        do_req(0, 1, 0, 6'h05, 0, bc);
        chk("i_busy_cycles", bc, 6);
        chk("i_rdata", I_READDATA, 32'hDEADBEEF);
        chk("i_mem_read_cycles", rd_cyc - r0, 5);

        r0 = rd_cyc; w0 = wr_cyc;
        do_req(1, 0, 1, 6'h3F, 32'h12345678, bc);
        chk("d_wr_busy_cycles", bc, 6);
        chk("d_wr_addr", w_addr, 6'h3F);
        chk("d_wr_data", w_data, 32'h12345678);
        chk("d_wr_rdata_hold", D_READDATA, 0);
        chk("d_wr_cycles", wr_cyc - w0, 5);
        chk("d_wr_no_read", rd_cyc - r0, 0);

        r0 = rd_cyc; w0 = wr_cyc;
        do_req(1, 1, 1, 6'h09, 32'hCAFEF00D, bc);
        chk("rw_no_read", rd_cyc - r0, 0);
        chk("rw_write_cycles", wr_cyc - w0, 5);
        chk("rw_addr", w_addr, 6'h09);
        chk("rw_data", w_data, 32'hCAFEF00D);

        fork
            do_req(1, 1, 0, 6'h01, 0, bc);
            begin
                @(posedge CLK);
                repeat (3) @(posedge CLK);
                #2 D_ADDRESS = 6'h02;
                @(negedge CLK);
                chk("addr_latched", MEM_ADDRESS, 6'h01);
            end
        join
        chk("addr_latched_rdata", D_READDATA, fn(6'h01));

        // simultaneous requests from reset pointer: D,I,D,I in both modes
        pulse_reset();
        repeat (2) fork
            do_req(1, 1, 0, 6'd20, 0, bc);
            do_req(0, 1, 0, 6'd10, 0, bc2);
        join
        exp_ord = '{6'd20, 6'd10, 6'd20, 6'd10};
        chk("tie_log_size", grant_log.size(), 4);
        for (int n = 0; n < 4; n++) chk($sformatf("tie_order_%0d", n), grant_log[n], exp_ord[n]);
        chk("tie_i_rdata", I_READDATA, fn(6'd10));
        chk("tie_d_rdata", D_READDATA, fn(6'd20));

        // after a data-only grant the tie outcome depends on the arbitration mode
        do_req(1, 0, 1, 6'h21, 32'h55AA55AA, bc);
        grant_log.delete();
        fork
            do_req(1, 1, 0, 6'd20, 0, bc);
            do_req(0, 1, 0, 6'd10, 0, bc2);
        join
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord[0] = 6'd10; exp_ord[1] = 6'd20;
`else
        exp_ord[0] = 6'd20; exp_ord[1] = 6'd10;
`endif
        chk("tie2_log_size", grant_log.size(), 2);
        for (int n = 0; n < 2; n++) chk($sformatf("tie2_order_%0d", n), grant_log[n], exp_ord[n]);

        // reset abandons an in-flight instruction read
        @(posedge CLK); #1 I_READ = 1; I_ADDRESS = 6'h07;
        @(posedge CLK);
        @(posedge CLK); #1 RESET = 1;
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_mem_read", MEM_READ, 0);
        chk("abort_i_rdata", I_READDATA, 0);
        chk("abort_i_busy", I_BUSYWAIT, 1);
        RESET = 0;
        bc = 0;
        while (bc < 200) begin
            @(negedge CLK);
            if (!I_BUSYWAIT) break;
            bc++;
        end
        chk("abort_resume_busy", bc, 5);
        chk("abort_resume_rdata", I_READDATA, fn(6'h07));
        @(posedge CLK); #1 I_READ = 0;

        // randomized traffic against the reference model
        pulse_reset();
        for (int a = 0; a < 64; a++) ref_mem[a] = fn(6'(a));
        d_last = 0;
        sb_on = 1;
        fork
            for (int n = 0; n < 25; n++) begin
                automatic logic [5:0] a = 6'($urandom_range(0, 31));
                automatic int b;
                i_q.push_back(ref_mem[a]);
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                do_req(0, 1, 0, a, 0, b);
            end
            for (int n = 0; n < 25; n++) begin
                automatic logic [5:0] a = 6'(32 + $urandom_range(0, 31));
                automatic logic [31:0] wd = $urandom;
                automatic int op = $urandom_range(0, 2);
                automatic int b;
                if (op == 0) begin
                    d_q.push_back('{1'b0, a, 32'h0, ref_mem[a]});
                    d_last = ref_mem[a];
                end else begin
                    ref_mem[a] = wd;
                    d_q.push_back('{1'b1, a, wd, d_last});
                end
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                do_req(1, op != 1, op != 0, a, wd, b);
            end
        join
        repeat (3) @(negedge CLK);
        sb_on = 0;
        chk("i_q_drained", i_q.size(), 0);
        chk("d_q_drained", d_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
